// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge detector.
//   mode_e     : magnitude mode selector (L1, MAX, THRESH, GX only)
//   state_e    : frame sequencing states (FILL, RUN, FLUSH)
//   saturate() : clamp an unsigned value to an n-bit all-ones ceiling
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_L1     = 2'd0,
    MODE_MAX    = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_GX     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Clamp val to 2^bits-1; callers cast the result down to their own width.
  function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned bits);
    logic [31:0] max_v;
    max_v = (32'd1 << bits) - 32'd1;
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/window_3x3.sv
// 3x3 sliding window over a raster pixel stream.
//   clock, reset : clock and async active-low reset (pointer only)
//   shift_en     : accept pix_in and advance the window by one pixel
//   pix_in       : incoming pixel (bottom-right of the next window)
//   win          : [row][col] taps, row 0 = top, col 0 = left
// The right-hand column is the live incoming column, so the taps show the
// window that will be complete once pix_in is accepted this cycle.
module window_3x3 #(
  parameter int unsigned IMG_WIDTH  = 540,
  parameter int unsigned PIXEL_BITS = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  shift_en,
  input  logic [PIXEL_BITS-1:0]                 pix_in,
  output logic [2:0][2:0][PIXEL_BITS-1:0]       win
);

  localparam int unsigned AW = $clog2(IMG_WIDTH);

  logic [PIXEL_BITS-1:0] lb1 [IMG_WIDTH];
  logic [PIXEL_BITS-1:0] lb2 [IMG_WIDTH];
  logic [AW-1:0]         ptr_q;
  logic [AW-1:0]         ptr_d;
  logic [2:0][1:0][PIXEL_BITS-1:0] win_q;
  logic [2:0][PIXEL_BITS-1:0]      new_col;

  // Slot ptr holds the pixel one row back (lb1) and two rows back (lb2).
  assign new_col[0] = lb2[ptr_q];
  assign new_col[1] = lb1[ptr_q];
  assign new_col[2] = pix_in;

  always_comb begin
    ptr_d = ptr_q;
    if (shift_en) begin
      ptr_d = (ptr_q == AW'(IMG_WIDTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Line buffers: cascade one row older on every accepted pixel.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      lb1[ptr_q] <= pix_in;
      lb2[ptr_q] <= lb1[ptr_q];
    end
  end

  // Left and centre columns of the window.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= new_col[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
      win[r][2] = new_col[r];
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge detector between two FIFOs.
//   clock, reset         : clock and async active-low reset
//   mode, thresh         : magnitude mode / threshold, latched at frame start
//   gray_rd_en           : pop request to the input FIFO
//   gray_empty, gray_dout: input FIFO status and head pixel
//   img_out_wr_en        : registered output push
//   img_out_full         : output FIFO full
//   img_out_din          : registered output pixel
//   done                 : pulses on the completion of the frame's last write
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 540,
  parameter int unsigned IMG_HEIGHT = 720,
  parameter int unsigned PIXEL_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [PIXEL_BITS-1:0] thresh,
  output logic                  gray_rd_en,
  input  logic                  gray_empty,
  input  logic [PIXEL_BITS-1:0] gray_dout,
  output logic                  img_out_wr_en,
  input  logic                  img_out_full,
  output logic [PIXEL_BITS-1:0] img_out_din,
  output logic                  done
);

  localparam int unsigned PW    = PIXEL_BITS;
  localparam int unsigned GW    = PIXEL_BITS + 3;
  localparam int unsigned FRAME = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CW    = $clog2(FRAME);
  localparam int unsigned COLW  = $clog2(IMG_WIDTH);
  localparam int unsigned ROWW  = $clog2(IMG_HEIGHT);
  localparam int unsigned FW    = $clog2(IMG_WIDTH + 2);

  state_e          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [COLW-1:0] col_q, col_d;
  mode_e           mode_q, mode_d;
  logic [PW-1:0]   thr_q, thr_d;
  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   dout_q, dout_d;

  logic            slot_free_c;
  logic            wr_done_c;
  logic            rd_en_c;
  logic            flush_ld_c;
  logic            last_wr_c;

  logic [2:0][2:0][PW-1:0] win;
  logic [GW-1:0]        left_c, right_c, top_c, bot_c;
  logic signed [GW-1:0] gx_c, gy_c;
  logic [GW-1:0]        ax_c, ay_c, l1_c, mx_c;
  logic                 border_c;
  logic [PW-1:0]        pix_c;

  // Handshake qualifiers; reads are blocked while reset is held.
  assign slot_free_c = !wr_en_q || !img_out_full;
  assign wr_done_c   = wr_en_q && !img_out_full;
  assign rd_en_c     = reset && ((state_q == S_FILL) || (state_q == S_RUN))
                       && !gray_empty && slot_free_c;
  assign flush_ld_c  = (state_q == S_FLUSH) && (flush_cnt_q != FW'(IMG_WIDTH + 1))
                       && slot_free_c;
  assign last_wr_c   = (state_q == S_FLUSH) && (flush_cnt_q == FW'(IMG_WIDTH + 1))
                       && wr_done_c;

  assign gray_rd_en    = rd_en_c;
  assign img_out_wr_en = wr_en_q;
  assign img_out_din   = dout_q;
  assign done          = last_wr_c;

  window_3x3 #(
    .IMG_WIDTH  (IMG_WIDTH),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_win (
    .clock    (clock),
    .reset    (reset),
    .shift_en (rd_en_c),
    .pix_in   (gray_dout),
    .win      (win)
  );

  // Gradient and magnitude for the window completed by the current read.
  always_comb begin
    left_c  = GW'(win[0][0]) + GW'({win[1][0], 1'b0}) + GW'(win[2][0]);
    right_c = GW'(win[0][2]) + GW'({win[1][2], 1'b0}) + GW'(win[2][2]);
    top_c   = GW'(win[0][0]) + GW'({win[0][1], 1'b0}) + GW'(win[0][2]);
    bot_c   = GW'(win[2][0]) + GW'({win[2][1], 1'b0}) + GW'(win[2][2]);
    gx_c    = $signed(right_c) - $signed(left_c);
    gy_c    = $signed(bot_c) - $signed(top_c);
    ax_c    = gx_c[GW-1] ? $unsigned(-gx_c) : $unsigned(gx_c);
    ay_c    = gy_c[GW-1] ? $unsigned(-gy_c) : $unsigned(gy_c);
    l1_c    = ax_c + ay_c;
    mx_c    = (ax_c > ay_c) ? ax_c : ay_c;

    border_c = (row_q == '0) || (row_q == ROWW'(IMG_HEIGHT - 1))
            || (col_q == '0) || (col_q == COLW'(IMG_WIDTH - 1));

    pix_c = '0;
    if (!border_c) begin
      case (mode_q)
        MODE_L1:     pix_c = PW'(saturate(32'(l1_c), PW));
        MODE_MAX:    pix_c = PW'(saturate(32'(mx_c), PW));
        MODE_THRESH: pix_c = (l1_c >= GW'(thr_q)) ? '1 : '0;
        MODE_GX:     pix_c = PW'(saturate(32'(ax_c), PW));
        default:     pix_c = '0;
      endcase
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    wr_en_d     = wr_en_q;
    dout_d      = dout_q;

    if (wr_done_c) begin
      wr_en_d = 1'b0;
    end

    case (state_q)
      S_FILL: begin
        if (rd_en_c) begin
          if (in_cnt_q == '0) begin
            mode_d = mode_e'(mode);
            thr_d  = thresh;
          end
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_cnt_q == CW'(IMG_WIDTH)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rd_en_c) begin
          wr_en_d  = 1'b1;
          dout_d   = pix_c;
          in_cnt_d = in_cnt_q + CW'(1);
          if (col_q == COLW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + ROWW'(1);
          end else begin
            col_d = col_q + COLW'(1);
          end
          if (in_cnt_q == CW'(FRAME - 1)) begin
            state_d  = S_FLUSH;
            in_cnt_d = '0;
          end
        end
      end
      S_FLUSH: begin
        // Trailing rows/columns are all border pixels, so flush writes zeros.
        if (flush_ld_c) begin
          wr_en_d     = 1'b1;
          dout_d      = '0;
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
        if (last_wr_c) begin
          state_d     = S_FILL;
          flush_cnt_d = '0;
          row_d       = '0;
          col_d       = '0;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FILL;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= MODE_L1;
      thr_q       <= '0;
      wr_en_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      wr_en_q     <= wr_en_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 frame with 8-bit pixels.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       gray_rd_en;
  logic       gray_empty;
  logic [7:0] gray_dout;
  logic       img_out_wr_en;
  logic       img_out_full;
  logic [7:0] img_out_din;
  logic       done;

  always #5 clock = ~clock;

  sobel_stream #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIXEL_BITS (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .thresh        (thresh),
    .gray_rd_en    (gray_rd_en),
    .gray_empty    (gray_empty),
    .gray_dout     (gray_dout),
    .img_out_wr_en (img_out_wr_en),
    .img_out_full  (img_out_full),
    .img_out_din   (img_out_din),
    .done          (done)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] src   [0:2*N-1];
  logic [7:0] exp_q [0:2*N-1];
  int src_n, src_idx;
  int wr_cnt, rd_cnt, done_cnt;
  int sw_at = -1;
  logic [1:0] sw_mode;
  logic [7:0] sw_thr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected pixel for a column-step frame: border 0, cols 3/4 edge_v, else mid_v.
  function automatic logic [7:0] step_exp(input int k, input logic [7:0] edge_v,
                                          input logic [7:0] mid_v);
    int r, c;
    r = k / W;
    c = k % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    if (c == 3 || c == 4) return edge_v;
    return mid_v;
  endfunction

  task automatic load_frames(input int frames, input logic [7:0] lo, input logic [7:0] hi);
    for (int i = 0; i < frames * N; i++) src[i] = ((i % W) < 4) ? lo : hi;
    src_n   = frames * N;
    src_idx = 0;
  endtask

  task automatic fill_exp(input int base, input logic [7:0] edge_v, input logic [7:0] mid_v);
    for (int k = 0; k < N; k++) exp_q[base + k] = step_exp(k, edge_v, mid_v);
  endtask

  // Drive inputs at negedge, sample handshakes #1 later (values seen by next posedge).
  task automatic run_stream(input int n_wr, input int rd_stop, input bit stall);
    int cyc;
    logic prev_hold;
    logic [7:0] prev_din;
    cyc = 0; prev_hold = 1'b0; prev_din = '0;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
    while (wr_cnt < n_wr && rd_cnt < rd_stop && cyc < 3000) begin
      @(negedge clock);
      gray_empty   = (src_idx >= src_n) || (stall && $urandom_range(0, 3) == 0);
      gray_dout    = (src_idx < src_n) ? src[src_idx] : 8'd0;
      img_out_full = stall && ($urandom_range(0, 2) == 0);
      if (wr_cnt == sw_at) begin
        mode   = sw_mode;
        thresh = sw_thr;
      end
      #1;
      if (prev_hold) begin
        check_eq("hold_wr_en", 32'(img_out_wr_en), 32'd1);
        check_eq("hold_din", 32'(img_out_din), 32'(prev_din));
      end
      prev_hold = img_out_wr_en && img_out_full;
      prev_din  = img_out_din;
      if (done) done_cnt++;
      if (gray_rd_en) begin
        src_idx++;
        rd_cnt++;
      end
      if (img_out_wr_en && !img_out_full) begin
        check_eq("pix", 32'(img_out_din), 32'(exp_q[wr_cnt]));
        check_eq("done_on_wr", 32'(done), 32'(((wr_cnt + 1) % N) == 0));
        wr_cnt++;
      end
      cyc++;
    end
    if (cyc >= 3000) check_eq("timeout_writes", 32'(wr_cnt), 32'(n_wr));
  endtask

  task automatic frame_test(input int frames, input bit stall);
    run_stream(frames * N, 1 << 30, stall);
    check_eq("n_writes", 32'(wr_cnt), 32'(frames * N));
    check_eq("n_done", 32'(done_cnt), 32'(frames));
    @(negedge clock);
    gray_empty = 1'b1;
    img_out_full = 1'b0;
    #1;
    check_eq("idle_wr_en", 32'(img_out_wr_en), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_rd_en", 32'(gray_rd_en), 32'd0);
    check_eq("rst_wr_en", 32'(img_out_wr_en), 32'd0);
    check_eq("rst_din", 32'(img_out_din), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0; mode = 2'd0; thresh = 8'd0;
    gray_empty = 1'b0; gray_dout = 8'd77; img_out_full = 1'b0;
    src_n = 0; src_idx = 0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs();
    gray_empty = 1'b1;
    @(negedge clock);
    reset = 1'b1;

    // Constant frame: no gradient anywhere.
    load_frames(1, 8'd100, 8'd100); fill_exp(0, 8'd0, 8'd0);
    mode = 2'd0; frame_test(1, 1'b0);

    // Step 0 -> 200: gx=800 saturates in L1, MAX and GX_ONLY.
    load_frames(1, 8'd0, 8'd200); fill_exp(0, 8'd255, 8'd0);
    mode = 2'd0; frame_test(1, 1'b0);
    load_frames(1, 8'd0, 8'd200); mode = 2'd1; frame_test(1, 1'b0);
    load_frames(1, 8'd0, 8'd200); mode = 2'd3; frame_test(1, 1'b0);

    // Step 0 -> 40: L1 = 160; thresholds either side of it.
    load_frames(1, 8'd0, 8'd40); fill_exp(0, 8'd160, 8'd0);
    mode = 2'd0; frame_test(1, 1'b0);
    load_frames(1, 8'd0, 8'd40); fill_exp(0, 8'd255, 8'd0);
    mode = 2'd2; thresh = 8'd100; frame_test(1, 1'b0);
    load_frames(1, 8'd0, 8'd40); fill_exp(0, 8'd0, 8'd0);
    mode = 2'd2; thresh = 8'd161; frame_test(1, 1'b0);

    // Random backpressure on both sides must not change the stream.
    load_frames(1, 8'd0, 8'd200); fill_exp(0, 8'd255, 8'd0);
    mode = 2'd0; thresh = 8'd0; frame_test(1, 1'b1);

    // Abort after 20 reads, then two back-to-back frames.
    load_frames(1, 8'd0, 8'd200); fill_exp(0, 8'd255, 8'd0);
    mode = 2'd0;
    run_stream(N, 20, 1'b0);
    check_eq("abort_reads", 32'(rd_cnt), 32'd20);
    @(negedge clock);
    reset = 1'b0; gray_empty = 1'b0; img_out_full = 1'b0;
    @(negedge clock);
    #1;
    check_reset_outputs();
    gray_empty = 1'b1;
    @(negedge clock);
    reset = 1'b1;

    // Frame 1 stays L1 despite a mid-frame switch; frame 2 is THRESH at 0.
    load_frames(2, 8'd0, 8'd200);
    fill_exp(0, 8'd255, 8'd0);
    fill_exp(N, 8'd255, 8'd255);
    mode = 2'd0; thresh = 8'd0;
    sw_at = 10; sw_mode = 2'd2; sw_thr = 8'd0;
    frame_test(2, 1'b0);
    sw_at = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
